// File: rtl/iter_mult_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
// FSM state encodings, Booth digit operations and the digit-counter width helper.
package iter_mult_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Radix-4 Booth digit operations
    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_op_t;

    // Bits needed to count digits 0..iter-1 (at least one bit)
    function automatic int cnt_width(input int iter);
        int w;
        w = $clog2(iter);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/iter_booth_mult_digit_sel.sv
// booth_digit_sel: recodes one radix-4 Booth digit from three multiplier bits
// and produces the partial product as select/invert of the multiplicand.
// Negative digits are returned ones-complemented with cin=1, so the carry-in
// of the accumulator adder completes the two's complement negation.
module booth_digit_sel
    import iter_mult_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic [2:0]    bits,
    input  logic [AW-1:0] mcand,
    output logic [AW-1:0] pp,
    output logic          cin
);

    booth_op_t     op_s;
    logic          sel_one_s;
    logic          sel_two_s;
    logic          neg_s;
    logic [AW-1:0] mag_s;

    // Recode {b[2k+1], b[2k], b[2k-1]} into a digit in {-2,-1,0,+1,+2}
    always_comb begin
        op_s = BOOTH_ZERO;
        case (bits)
            3'b000:  op_s = BOOTH_ZERO;
            3'b001:  op_s = BOOTH_POS1;
            3'b010:  op_s = BOOTH_POS1;
            3'b011:  op_s = BOOTH_POS2;
            3'b100:  op_s = BOOTH_NEG2;
            3'b101:  op_s = BOOTH_NEG1;
            3'b110:  op_s = BOOTH_NEG1;
            3'b111:  op_s = BOOTH_ZERO;
            default: op_s = BOOTH_ZERO;
        endcase
    end

    assign sel_one_s = (op_s == BOOTH_POS1) || (op_s == BOOTH_NEG1);
    assign sel_two_s = (op_s == BOOTH_POS2) || (op_s == BOOTH_NEG2);
    assign neg_s     = (op_s == BOOTH_NEG1) || (op_s == BOOTH_NEG2);

    // and2 select of A or 2A, then xor2 conditional inversion
    assign mag_s = ({AW{sel_one_s}} & mcand) | ({AW{sel_two_s}} & {mcand[AW-2:0], 1'b0});
    assign pp    = mag_s ^ {AW{neg_s}};
    assign cin   = neg_s;

endmodule

// File: rtl/iter_booth_mult.sv
// iter_booth_mult: multi-cycle radix-4 Booth multiplier, one digit per clock.
// Handshaked input (in_valid/in_ready) and output (out_valid/out_ready).
// Optional feature macro: ITER_MULT_ACC_EN adds port c and computes a*b+c.
// The multiplicand register shifts left by two each digit so the partial
// product lands at weight 4^k; the multiplier register shifts right by two.
module iter_booth_mult
    import iter_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef ITER_MULT_ACC_EN
    input  logic [2*WIDTH-1:0]   c,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int AW   = 2 * WIDTH + 2;
    localparam int EW   = WIDTH + 2;
    localparam int CW   = cnt_width(ITER);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("iter_booth_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [AW-1:0]      mcand_r;
    logic [EW:0]        mult_r;
    logic [AW-1:0]      acc_r;
    logic [2*WIDTH-1:0] p_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [AW-1:0]      a_ext_s;
    logic [EW-1:0]      b_ext_s;
    logic [AW-1:0]      acc_init_s;
    logic [AW-1:0]      pp_s;
    logic               cin_s;
    logic [AW-1:0]      acc_sum_s;
    logic               last_digit_s;

    // Sign- or zero-extend operands for the capture edge
    always_comb begin
        if (in_signed) begin
            a_ext_s = {{(AW-WIDTH){a[WIDTH-1]}}, a};
            b_ext_s = {{(EW-WIDTH){b[WIDTH-1]}}, b};
        end else begin
            a_ext_s = {{(AW-WIDTH){1'b0}}, a};
            b_ext_s = {{(EW-WIDTH){1'b0}}, b};
        end
    end

`ifdef ITER_MULT_ACC_EN
    assign acc_init_s = {2'b00, c};
`else
    assign acc_init_s = {AW{1'b0}};
`endif

    booth_digit_sel #(
        .AW (AW)
    ) u_digit_sel (
        .bits  (mult_r[2:0]),
        .mcand (mcand_r),
        .pp    (pp_s),
        .cin   (cin_s)
    );

    assign acc_sum_s    = acc_r + pp_s + {{(AW-1){1'b0}}, cin_s};
    assign last_digit_s = (cnt_r == CW'(ITER - 1));

    // FSM, operand shift registers, accumulator and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            mcand_r     <= {AW{1'b0}};
            mult_r      <= {(EW+1){1'b0}};
            acc_r       <= {AW{1'b0}};
            p_r         <= {(2*WIDTH){1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand_r    <= a_ext_s;
                        mult_r     <= {b_ext_s, 1'b0};
                        acc_r      <= acc_init_s;
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ST_RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_sum_s;
                    mcand_r <= {mcand_r[AW-3:0], 2'b00};
                    mult_r  <= {2'b00, mult_r[EW:2]};
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_digit_s) begin
                        p_r         <= acc_sum_s[2*WIDTH-1:0];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign p         = p_r;

endmodule
